// File: rtl/smc_soc_cpu_jtag_pkg.sv
// Shared types and constants for the CPU JTAG scan master.
package smc_soc_cpu_jtag_pkg;

    localparam int DEFAULT_DR_WIDTH = 38;
    localparam int DEFAULT_IR_WIDTH = 2;

    // Virtual IR codes understood by the CPU debug module
    localparam logic [1:0] OCIMEM    = 2'd0;
    localparam logic [1:0] TRACEMEM  = 2'd1;
    localparam logic [1:0] BREAK     = 2'd2;
    localparam logic [1:0] TRACECTRL = 2'd3;

    // Scan sequencer states, in the order a scan walks through them
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_UIR  = 3'd1,
        ST_CDR  = 3'd2,
        ST_SDR  = 3'd3,
        ST_UDR  = 3'd4,
        ST_RESP = 3'd5
    } scan_state_e;

endpackage

// File: rtl/smc_soc_cpu_jtag_tck_gen.sv
// Free-running test-clock generator. tck toggles every TCK_DIV clk cycles;
// rise_o/fall_o are single-cycle strobes asserted in the cycle whose clock
// edge drives tck high/low, so logic enabled by them updates together with tck.
module smc_soc_cpu_jtag_tck_gen #(
    parameter int TCK_DIV = 2
) (
    input  logic clk_i,
    input  logic reset_i,
    output logic tck_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int CW = $clog2(TCK_DIV + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tck_q, tck_d;
    logic          wrap;

    // Divider counter and tck toggle decision
    always_comb begin
        wrap   = (cnt_q == CW'(TCK_DIV - 1));
        cnt_d  = wrap ? '0 : cnt_q + CW'(1);
        tck_d  = wrap ? ~tck_q : tck_q;
        rise_o = wrap & ~tck_q;
        fall_o = wrap & tck_q;
        tck_o  = tck_q;
    end

    // Divider state; tck starts low
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cnt_q <= '0;
            tck_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tck_q <= tck_d;
        end
    end

endmodule

// File: rtl/smc_soc_cpu_jtag_scan_master.sv
// Host-side virtual-JTAG scan initiator: takes {IR, DR payload} commands,
// walks UIR -> CDR -> SDR -> UDR on the generated tck and returns the
// captured tdo bits as a response word.
module smc_soc_cpu_jtag_scan_master
    import smc_soc_cpu_jtag_pkg::*;
#(
    parameter int DR_WIDTH = DEFAULT_DR_WIDTH,
    parameter int IR_WIDTH = DEFAULT_IR_WIDTH,
    parameter int TCK_DIV  = 2
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                cmd_valid_i,
    output logic                cmd_ready_o,
    input  logic [IR_WIDTH-1:0] cmd_ir_i,
    input  logic [DR_WIDTH-1:0] cmd_data_i,
    output logic                rsp_valid_o,
    input  logic                rsp_ready_i,
    output logic [DR_WIDTH-1:0] rsp_data_o,
    output logic                vji_tck_o,
    output logic                vji_tdi_o,
    input  logic                vji_tdo_i,
    output logic [IR_WIDTH-1:0] vji_ir_in_o,
    output logic                vji_uir_o,
    output logic                vji_cdr_o,
    output logic                vji_sdr_o,
    output logic                vji_udr_o,
    output logic                vji_rti_o
);

    localparam int CNT_W = $clog2(DR_WIDTH + 1);

    scan_state_e         state_q, state_d;
    logic [DR_WIDTH-1:0] sr_q, sr_d;
    logic [IR_WIDTH-1:0] ir_pend_q, ir_pend_d;
    logic [IR_WIDTH-1:0] ir_in_q, ir_in_d;
    logic                start_q, start_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                tdo_cap_q, tdo_cap_d;
    logic                tck, tck_rise, tck_fall;

    smc_soc_cpu_jtag_tck_gen #(
        .TCK_DIV (TCK_DIV)
    ) u_tck_gen (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .tck_o   (tck),
        .rise_o  (tck_rise),
        .fall_o  (tck_fall)
    );

    // Next-state and Moore outputs; every transition except the response
    // handshake is gated by the tck falling-edge strobe
    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        ir_pend_d   = ir_pend_q;
        ir_in_d     = ir_in_q;
        start_d     = start_q;
        cnt_d       = cnt_q;
        tdo_cap_d   = tdo_cap_q;
        cmd_ready_o = 1'b0;
        rsp_valid_o = 1'b0;
        rsp_data_o  = '0;
        vji_tdi_o   = 1'b0;
        vji_uir_o   = 1'b0;
        vji_cdr_o   = 1'b0;
        vji_sdr_o   = 1'b0;
        vji_udr_o   = 1'b0;
        vji_rti_o   = 1'b0;
        vji_tck_o   = tck;
        vji_ir_in_o = ir_in_q;

        case (state_q)
            ST_IDLE: begin
                vji_rti_o   = 1'b1;
                cmd_ready_o = ~start_q;
                if (!start_q) begin
                    if (cmd_valid_i) begin
                        ir_pend_d = cmd_ir_i;
                        sr_d      = cmd_data_i;
                        start_d   = 1'b1;
                    end
                end else if (tck_fall) begin
                    // IR becomes visible only when the scan actually starts
                    state_d = ST_UIR;
                    start_d = 1'b0;
                    ir_in_d = ir_pend_q;
                end
            end
            ST_UIR: begin
                vji_uir_o = 1'b1;
                if (tck_fall) state_d = ST_CDR;
            end
            ST_CDR: begin
                vji_cdr_o = 1'b1;
                if (tck_fall) begin
                    state_d = ST_SDR;
                    cnt_d   = '0;
                end
            end
            ST_SDR: begin
                vji_sdr_o = 1'b1;
                vji_tdi_o = sr_q[0];
                if (tck_rise) tdo_cap_d = vji_tdo_i;
                if (tck_fall) begin
                    // Captured bit enters at the MSB so the first one ends in bit 0
                    sr_d  = {tdo_cap_q, sr_q[DR_WIDTH-1:1]};
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(DR_WIDTH - 1)) state_d = ST_UDR;
                end
            end
            ST_UDR: begin
                vji_udr_o = 1'b1;
                if (tck_fall) state_d = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid_o = 1'b1;
                rsp_data_o  = sr_q;
                if (rsp_ready_i) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Sequencer state registers; reset drops any in-flight scan
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= ST_IDLE;
            sr_q      <= '0;
            ir_pend_q <= '0;
            ir_in_q   <= '0;
            start_q   <= 1'b0;
            cnt_q     <= '0;
            tdo_cap_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            ir_pend_q <= ir_pend_d;
            ir_in_q   <= ir_in_d;
            start_q   <= start_d;
            cnt_q     <= cnt_d;
            tdo_cap_q <= tdo_cap_d;
        end
    end

endmodule

// File: tb/tb_smc_soc_cpu_jtag_scan_master.sv
// Self-checking bench for the JTAG scan master: a timeline model predicts
// every output from the clk count since reset and the accepted commands.
module tb_smc_soc_cpu_jtag_scan_master;
    import smc_soc_cpu_jtag_pkg::*;

    localparam int W = 38;
    localparam int D = 2;
    localparam int P = 2 * D;

    logic clk = 1'b0;
    logic rst;

    logic         cmd_valid, cmd_ready, rsp_valid, rsp_ready;
    logic [1:0]   cmd_ir, ir_in;
    logic [W-1:0] cmd_data, rsp_data;
    logic         tck, tdi, tdo, uir, cdr, sdr, udr, rti;

    logic         cmd_valid2, cmd_ready2, rsp_valid2, rsp_ready2;
    logic [1:0]   cmd_ir2, ir_in2;
    logic [W-1:0] cmd_data2, rsp_data2;
    logic         tck2, tdi2, tdo2, uir2, cdr2, sdr2, udr2, rti2;

    int asserts = 0;
    int fails   = 0;
    int cyc     = 0;

    // Model state
    int           n = 0;
    bit           busy = 1'b0;
    int           u = 0;
    logic [W-1:0] m_data = '0, m_rsp = '0;
    logic [1:0]   m_ir_pend = '0, m_ir_last = '0;
    int           acc_cnt = 0, done_cnt = 0;
    int           tdo_mode;
    logic [W-1:0] tdo_pat;
    int           tdo_k;

    // Monitor counters
    int uir_cyc = 0, cdr_cyc = 0, sdr_cyc = 0, udr_cyc = 0, uir_rises = 0;
    int uir_start = 0, span = 0;
    logic uir_p = 1'b0, rv_p = 1'b0;

    always #5 clk = ~clk;

    smc_soc_cpu_jtag_scan_master #(.DR_WIDTH(W), .IR_WIDTH(2), .TCK_DIV(D)) dut (
        .clk_i(clk), .reset_i(rst), .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
        .cmd_ir_i(cmd_ir), .cmd_data_i(cmd_data), .rsp_valid_o(rsp_valid),
        .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data), .vji_tck_o(tck), .vji_tdi_o(tdi),
        .vji_tdo_i(tdo), .vji_ir_in_o(ir_in), .vji_uir_o(uir), .vji_cdr_o(cdr),
        .vji_sdr_o(sdr), .vji_udr_o(udr), .vji_rti_o(rti));

    smc_soc_cpu_jtag_scan_master #(.DR_WIDTH(W), .IR_WIDTH(2), .TCK_DIV(1)) dut2 (
        .clk_i(clk), .reset_i(rst), .cmd_valid_i(cmd_valid2), .cmd_ready_o(cmd_ready2),
        .cmd_ir_i(cmd_ir2), .cmd_data_i(cmd_data2), .rsp_valid_o(rsp_valid2),
        .rsp_ready_i(rsp_ready2), .rsp_data_o(rsp_data2), .vji_tck_o(tck2), .vji_tdi_o(tdi2),
        .vji_tdo_i(tdo2), .vji_ir_in_o(ir_in2), .vji_uir_o(uir2), .vji_cdr_o(cdr2),
        .vji_sdr_o(sdr2), .vji_udr_o(udr2), .vji_rti_o(rti2));

    assign tdo2 = tdi2;

    // Scan period index: -2 idle, -1 waiting for first fall, 0 UIR, 1 CDR,
    // 2..W+1 SDR bit k-2, W+2 UDR, >= W+3 response pending
    function automatic int phase_of(input bit b, input int nn, input int uu);
        if (!b) return -2;
        if (nn < uu) return -1;
        return (nn - uu) / P;
    endfunction

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        asserts++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s t=%0t got=%h exp=%h", nm, $time, got, exp);
        end
    endtask

    // tdo source: loopback, tied high, or a per-bit pattern
    always_comb begin
        tdo   = 1'b0;
        tdo_k = phase_of(busy, n, u);
        case (tdo_mode)
            0: tdo = tdi;
            1: tdo = 1'b1;
            default: if (tdo_k >= 2 && tdo_k < W + 2) tdo = tdo_pat[tdo_k-2];
        endcase
    end

    // Timeline model: counts clk edges since reset and tracks command/response handshakes
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            n         <= 0;
            busy      <= 1'b0;
            u         <= 0;
            m_ir_last <= '0;
        end else begin
            n <= n + 1;
            if (!busy) begin
                if (cmd_valid) begin
                    busy      <= 1'b1;
                    u         <= ((n + 1) / P + 1) * P;
                    m_data    <= cmd_data;
                    m_ir_pend <= cmd_ir;
                    m_rsp     <= (tdo_mode == 0) ? cmd_data : (tdo_mode == 1) ? '1 : tdo_pat;
                    acc_cnt   <= acc_cnt + 1;
                end
            end else if (n >= u + (W + 3) * P && rsp_ready) begin
                busy      <= 1'b0;
                m_ir_last <= m_ir_pend;
                done_cnt  <= done_cnt + 1;
            end
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Per-cycle comparison of every output against the model
    always @(negedge clk) begin : cmp
        int k;
        logic e_sdr, e_tdi;
        logic [1:0] e_ir;
        logic [10:0] got_v, exp_v;
        k     = phase_of(busy, n, u);
        e_sdr = (k >= 2) && (k < W + 2);
        e_tdi = 1'b0;
        if (e_sdr) e_tdi = m_data[k-2];
        e_ir  = (k >= 0) ? m_ir_pend : m_ir_last;
        exp_v = {1'((n / D) % 2), k == -2, k < 0, k == 0, k == 1, e_sdr, k == W + 2,
                 e_tdi, e_ir, k >= W + 3};
        got_v = {tck, cmd_ready, rti, uir, cdr, sdr, udr, tdi, ir_in, rsp_valid};
        chk("ctrl{tck,rdy,rti,uir,cdr,sdr,udr,tdi,ir,rv}", 64'(got_v), 64'(exp_v));
        chk("rsp_data", 64'(rsp_data), (k >= W + 3) ? 64'(m_rsp) : 64'd0);
    end

    // Strobe activity monitor
    always @(negedge clk) begin
        if (uir) uir_cyc <= uir_cyc + 1;
        if (cdr) cdr_cyc <= cdr_cyc + 1;
        if (sdr) sdr_cyc <= sdr_cyc + 1;
        if (udr) udr_cyc <= udr_cyc + 1;
        if (uir && !uir_p) begin
            uir_rises <= uir_rises + 1;
            uir_start <= cyc;
        end
        if (rsp_valid && !rv_p) span <= cyc - uir_start;
        uir_p <= uir;
        rv_p  <= rsp_valid;
    end

    task automatic send_cmd(input logic [1:0] ir, input logic [W-1:0] d);
        int a0, b;
        a0 = acc_cnt;
        @(negedge clk);
        cmd_ir = ir; cmd_data = d; cmd_valid = 1'b1;
        b = 0;
        while (acc_cnt == a0 && b < 1000) begin @(negedge clk); b++; end
        cmd_valid = 1'b0;
        chk("accept_timeout", 64'(acc_cnt != a0), 64'd1);
    endtask

    task automatic wait_resp(input logic [W-1:0] exp, input int policy);
        int d0, b;
        d0 = done_cnt;
        b = 0;
        while (!rsp_valid && b < 1000) begin
            rsp_ready = (policy == 1) ? 1'b0 : 1'($urandom % 2);
            @(negedge clk); b++;
        end
        chk("rsp_valid_timeout", 64'(rsp_valid), 64'd1);
        chk("rsp_data_expected", 64'(rsp_data), 64'(exp));
        b = 0;
        while (done_cnt == d0 && b < 1000) begin
            rsp_ready = (policy == 1) ? 1'b1 : 1'($urandom % 2);
            @(negedge clk); b++;
        end
        rsp_ready = 1'b0;
        chk("resp_done_timeout", 64'(done_cnt != d0), 64'd1);
    endtask

    task automatic do_scan(input logic [1:0] ir, input logic [W-1:0] d, input int mode,
                           input logic [W-1:0] exp, input int policy);
        int u0, c0, s0, d0, r0;
        tdo_mode = mode;
        u0 = uir_cyc; c0 = cdr_cyc; s0 = sdr_cyc; d0 = udr_cyc; r0 = uir_rises;
        send_cmd(ir, d);
        wait_resp(exp, policy);
        chk("uir_cycles", 64'(uir_cyc - u0), 64'(P));
        chk("cdr_cycles", 64'(cdr_cyc - c0), 64'(P));
        chk("sdr_cycles", 64'(sdr_cyc - s0), 64'(W * P));
        chk("udr_cycles", 64'(udr_cyc - d0), 64'(P));
        chk("uir_pulses", 64'(uir_rises - r0), 64'd1);
        chk("uir_to_resp", 64'(span), 64'((W + 3) * P));
        $display("scan ir=%0d data=%h mode=%0d rsp=%h", ir, d, mode, exp);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int b, st, mode;
        logic [W-1:0] d, e;
        rst = 1'b1;
        cmd_valid = 1'b0; rsp_ready = 1'b0; cmd_ir = '0; cmd_data = '0;
        cmd_valid2 = 1'b0; rsp_ready2 = 1'b0; cmd_ir2 = '0; cmd_data2 = '0;
        tdo_mode = 0; tdo_pat = '0;
        repeat (3) @(negedge clk);
        chk("rst_tck", 64'(tck), 64'd0);
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("rst_rti", 64'(rti), 64'd1);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_data", 64'(rsp_data), 64'd0);
        chk("rst_ir_in", 64'(ir_in), 64'd0);
        rst = 1'b0;

        // Loopback with the reference pattern; 164 clk from UIR start to response
        do_scan(OCIMEM, 38'h2A_5555_AAAA, 0, 38'h2A_5555_AAAA, 1);
        chk("span_literal_164", 64'(span), 64'd164);

        // tdo tied high, zero payload
        do_scan(TRACEMEM, 38'h0, 1, 38'h3F_FFFF_FFFF, 0);

        // Back-to-back IR codes 3 then 1
        d = W'({$urandom, $urandom});
        do_scan(TRACECTRL, d, 0, d, 0);
        chk("ir_hold_idle", 64'(ir_in), 64'd3);
        d = W'({$urandom, $urandom});
        do_scan(TRACEMEM, d, 0, d, 1);

        // Response held for 50 clk with a competing command offered
        tdo_mode = 0;
        send_cmd(BREAK, 38'h15_0F0F_3C3C);
        b = 0;
        while (!rsp_valid && b < 1000) begin @(negedge clk); b++; end
        cmd_ir = TRACEMEM; cmd_data = 38'h3F_0000_0001; cmd_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            chk("hold_rsp_data", 64'(rsp_data), 64'h15_0F0F_3C3C);
            chk("hold_rsp_valid", 64'(rsp_valid), 64'd1);
            chk("hold_cmd_ready", 64'(cmd_ready), 64'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("simul_rsp_cleared", 64'(rsp_valid), 64'd0);
        chk("simul_cmd_ready", 64'(cmd_ready), 64'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
        wait_resp(38'h3F_0000_0001, 0);
        $display("hold scan done, follow-on rsp=%h", 38'h3F_0000_0001);

        // Reset in the middle of SDR bit 20
        tdo_mode = 2; tdo_pat = W'({$urandom, $urandom});
        send_cmd(BREAK, W'({$urandom, $urandom}));
        b = 0;
        while (phase_of(busy, n, u) != 22 && b < 1000) begin @(negedge clk); b++; end
        chk("reached_sdr_bit20", 64'(sdr), 64'd1);
        rst = 1'b1;
        #1;
        chk("midrst_tck", 64'(tck), 64'd0);
        chk("midrst_sdr", 64'(sdr), 64'd0);
        chk("midrst_tdi", 64'(tdi), 64'd0);
        chk("midrst_ir_in", 64'(ir_in), 64'd0);
        chk("midrst_rti", 64'(rti), 64'd1);
        chk("midrst_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        $display("reset mid-scan at sdr bit 20");
        tdo_pat = W'({$urandom, $urandom});
        do_scan(OCIMEM, W'({$urandom, $urandom}), 2, tdo_pat, 0);

        // Randomized scans
        for (int i = 0; i < 8; i++) begin
            mode = int'($urandom % 3);
            d = W'({$urandom, $urandom});
            tdo_pat = W'({$urandom, $urandom});
            e = (mode == 0) ? d : (mode == 1) ? '1 : tdo_pat;
            do_scan(2'($urandom), d, mode, e, int'($urandom % 2));
        end

        // TCK_DIV=1 instance: tck toggles every clk, loopback of 1
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("tck2_phase", 64'(tck2), 64'(n % 2));
        end
        cmd_ir2 = TRACECTRL; cmd_data2 = 38'h00_0000_0001; cmd_valid2 = 1'b1;
        b = 0;
        while (!cmd_ready2 && b < 100) begin @(negedge clk); b++; end
        @(negedge clk);
        cmd_valid2 = 1'b0;
        st = -1; b = 0;
        if (uir2) st = cyc;
        while (!rsp_valid2 && b < 500) begin
            @(negedge clk); b++;
            if (uir2 && st < 0) st = cyc;
        end
        chk("tck1_rsp_valid", 64'(rsp_valid2), 64'd1);
        chk("tck1_span_82", 64'(cyc - st), 64'd82);
        chk("tck1_rsp_data", 64'(rsp_data2), 64'h00_0000_0001);
        rsp_ready2 = 1'b1;
        @(negedge clk);
        rsp_ready2 = 1'b0;
        chk("tck1_back_idle", 64'(cmd_ready2), 64'd1);
        $display("tck_div1 scan rsp=%h", rsp_data2);

        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule
